cache_assoc_wb: RTL and testbench
=================================

CACHE_ASSOC_WB -- requirements
Module: cache_assoc_wb

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-003 Parameter WAYS, default 4, SHALL set the number of fully associative lines; it SHALL be a power of two and at least 2.
REQ-004 Parameter RAM_LAT, default 2, SHALL set the backing-RAM access cycles; it SHALL be at least 1.
REQ-005 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port req_valid, input, 1 bit: request present.
REQ-008 Port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W bits: word address.
REQ-010 Port req_wdata, input, DATA_W bits: write data.
REQ-011 Port req_ready, output, 1 bit: high only in IDLE.
REQ-012 Port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 Port resp_rdata, output, DATA_W bits: read data, valid with resp_valid.
REQ-014 Port resp_hit, output, 1 bit: 1 = request hit in cache, valid with resp_valid.
REQ-015 Port wb_count, output, 16 bits: number of dirty evictions written to RAM.

Function
REQ-016 Backing RAM SHALL be internal, 2^ADDR_W words, with every word initialised to its own address truncated to DATA_W bits at time zero.
REQ-017 A request SHALL be accepted on a clock edge where req_valid and req_ready are both high; inputs SHALL be registered at acceptance.
REQ-018 State machine SHALL have states IDLE, LOOKUP, WRITEBACK, FILL and RESPOND.
REQ-019 Transitions SHALL be: IDLE→LOOKUP on accept; LOOKUP→RESPOND on hit; LOOKUP→FILL on miss with a clean or invalid victim; LOOKUP→WRITEBACK on miss with a dirty victim; WRITEBACK→FILL after RAM_LAT cycles; FILL→RESPOND after RAM_LAT cycles; RESPOND→IDLE.
REQ-020 Latency from acceptance edge to resp_valid SHALL be 2 cycles on a hit, 2+RAM_LAT on a clean miss and 2+2*RAM_LAT on a dirty miss.
REQ-021 A hit SHALL require a valid line whose tag equals req_addr; multiple matches SHALL be impossible by construction.
REQ-022 Victim selection SHALL pick the lowest-index invalid line, otherwise the line with LRU age WAYS-1.
REQ-023 Each line SHALL hold an LRU age of log2(WAYS) bits; on access, the accessed line's age SHALL become 0 and every line with a smaller age SHALL increment by 1; ages SHALL remain a permutation of 0..WAYS-1.
REQ-024 WRITEBACK SHALL write the victim's data to RAM[victim tag] on its final cycle only, and SHALL increment wb_count, saturating at 0xFFFF.
REQ-025 FILL SHALL read RAM[req_addr] into the victim line, set valid=1, set tag=req_addr and set dirty=0.
REQ-026 Writes SHALL be write-allocate: after a hit or fill the line data SHALL become req_wdata and dirty SHALL become 1; RAM SHALL NOT be written.
REQ-027 On reads, resp_rdata SHALL present the line data; on writes, resp_rdata SHALL echo req_wdata.
REQ-028 resp_valid, resp_rdata and resp_hit SHALL be registered and SHALL be 0 outside RESPOND.
REQ-029 req_valid while req_ready is low SHALL be ignored and SHALL NOT be queued.

Reset
REQ-030 Reset SHALL force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_hit=0 and wb_count=0, and SHALL clear all valid and dirty bits.
REQ-031 Reset SHALL set each line's LRU age to its own index; RAM contents SHALL be unaffected by reset.
REQ-032 Reset mid-operation SHALL abandon the transaction with no response; a WRITEBACK interrupted before its final cycle SHALL leave RAM unmodified.

Configuration
REQ-033 With macro CACHE_STATS_EN defined, outputs hit_count and miss_count (16 bits each, saturating, cleared by reset) SHALL increment on each LOOKUP hit or miss; without the macro these ports and counters SHALL NOT exist.

Verification
REQ-034 After reset, read 0x10 SHALL produce resp_valid 4 cycles after acceptance with rdata=0x10 and hit=0; a repeat read of 0x10 SHALL return 0x10 with hit=1 at 2 cycles.
REQ-035 Write 0x20=0xAB (miss), then read 0x20, SHALL give hit=1 and rdata=0xAB, and RAM[0x20] SHALL still hold 0x20.
REQ-036 Writes to 0x01..0x04 followed by a read of 0x05 SHALL evict 0x01, give a latency of 6, leave RAM[0x01]=written data and set wb_count=1.
REQ-037 With lines 0x01..0x04 filled, a read of 0x01 followed by a miss on 0x05 SHALL evict 0x02, not 0x01.
REQ-038 Asserting reset during the 2nd cycle of WRITEBACK SHALL produce no resp_valid, leave RAM unchanged, and make the next read of any address a miss.
REQ-039 Asserting req_valid while req_ready=0 SHALL produce no extra response, and with CACHE_STATS_EN, hit_count+miss_count SHALL equal the number of accepted requests.

Source files
------------

// File: rtl/cache_assoc_wb.sv
// Fully associative write-back, write-allocate cache with true-LRU replacement and an internal backing RAM.
// Defining CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_assoc_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int WAYS    = 4,
    parameter int RAM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic [15:0]       wb_count
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);
    localparam int IDX_W     = $clog2(WAYS);
    localparam int CNT_W     = $clog2(RAM_LAT + 1);
    localparam int RAM_DEPTH = 1 << ADDR_W;
    localparam logic [IDX_W-1:0] AGE_OLDEST = IDX_W'(WAYS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(RAM_LAT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]  victim_q, victim_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_hit_q, resp_hit_d;
    logic [15:0]       wb_count_q, wb_count_d;

    logic [WAYS-1:0]   valid_q, valid_d;
    logic [WAYS-1:0]   dirty_q, dirty_d;
    logic [ADDR_W-1:0] tag_q  [WAYS];
    logic [ADDR_W-1:0] tag_d  [WAYS];
    logic [DATA_W-1:0] data_q [WAYS];
    logic [DATA_W-1:0] data_d [WAYS];
    logic [IDX_W-1:0]  age_q  [WAYS];
    logic [IDX_W-1:0]  age_d  [WAYS];

    logic              hit_s;
    logic [IDX_W-1:0]  hit_idx_s;
    logic [IDX_W-1:0]  victim_s;
    logic              touch_s;
    logic [IDX_W-1:0]  touch_idx_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rd_s [RAM_DEPTH];

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;
`endif

    // Backing RAM: each word powers up holding its own address and is never touched by reset.
    for (genvar gi = 0; gi < RAM_DEPTH; gi++) begin : g_ram
        logic [DATA_W-1:0] word_q = DATA_W'(gi);
        always_ff @(posedge clock) begin
            if (ram_we_s && (ram_waddr_s == ADDR_W'(gi))) begin
                word_q <= ram_wdata_s;
            end
        end
        assign ram_rd_s[gi] = word_q;
    end

    // Tag match and victim choice; a later invalid-line pass overrides the LRU pick.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        victim_s  = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_s     = (valid_q[i] && (tag_q[i] == addr_q)) ? 1'b1 : hit_s;
            hit_idx_s = (valid_q[i] && (tag_q[i] == addr_q)) ? IDX_W'(i) : hit_idx_s;
            victim_s  = (age_q[i] == AGE_OLDEST) ? IDX_W'(i) : victim_s;
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            victim_s = (!valid_q[i]) ? IDX_W'(i) : victim_s;
        end
    end

    // Transaction state machine and line updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_hit_d   = 1'b0;
        wb_count_d   = wb_count_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        touch_s      = 1'b0;
        touch_idx_s  = '0;
        ram_we_s     = 1'b0;
        ram_waddr_s  = tag_q[victim_q];
        ram_wdata_s  = data_q[victim_q];
`ifdef CACHE_STATS_EN
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    state_d     = S_LOOKUP;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_LOOKUP: begin
                cnt_d = '0;
                if (hit_s) begin
                    touch_s      = 1'b1;
                    touch_idx_s  = hit_idx_s;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    state_d      = S_RESPOND;
`ifdef CACHE_STATS_EN
                    hit_count_d  = (hit_count_q == 16'hFFFF) ? hit_count_q : hit_count_q + 16'd1;
`endif
                    if (write_q) begin
                        data_d[hit_idx_s]  = wdata_q;
                        dirty_d[hit_idx_s] = 1'b1;
                        resp_rdata_d       = wdata_q;
                    end else begin
                        resp_rdata_d = data_q[hit_idx_s];
                    end
                end else begin
                    victim_d = victim_s;
`ifdef CACHE_STATS_EN
                    miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
`endif
                    if (valid_q[victim_s] && dirty_q[victim_s]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_WRITEBACK: begin
                if (cnt_q == CNT_LAST) begin
                    // Gated by reset so an interrupted writeback never reaches RAM.
                    ram_we_s   = !reset;
                    wb_count_d = (wb_count_q == 16'hFFFF) ? wb_count_q : wb_count_q + 16'd1;
                    cnt_d      = '0;
                    state_d    = S_FILL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FILL: begin
                if (cnt_q == CNT_LAST) begin
                    valid_d[victim_q] = 1'b1;
                    tag_d[victim_q]   = addr_q;
                    touch_s           = 1'b1;
                    touch_idx_s       = victim_q;
                    resp_valid_d      = 1'b1;
                    state_d           = S_RESPOND;
                    if (write_q) begin
                        data_d[victim_q]  = wdata_q;
                        dirty_d[victim_q] = 1'b1;
                        resp_rdata_d      = wdata_q;
                    end else begin
                        data_d[victim_q]  = ram_rd_s[addr_q];
                        dirty_d[victim_q] = 1'b0;
                        resp_rdata_d      = ram_rd_s[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESPOND: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // LRU ages: the touched line becomes youngest, younger lines age by one.
    always_comb begin
        age_d = age_q;
        if (touch_s) begin
            for (int i = 0; i < WAYS; i++) begin
                if (IDX_W'(i) == touch_idx_s) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[touch_idx_s]) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end else begin
                    age_d[i] = age_q[i];
                end
            end
        end else begin
            age_d = age_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            victim_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            wb_count_q   <= 16'd0;
            valid_q      <= '0;
            dirty_q      <= '0;
            for (int i = 0; i < WAYS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
`ifdef CACHE_STATS_EN
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            wb_count_q   <= wb_count_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            age_q        <= age_d;
`ifdef CACHE_STATS_EN
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_hit   = resp_hit_q;
    assign wb_count   = wb_count_q;
`ifdef CACHE_STATS_EN
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Directed self-checking bench for cache_assoc_wb with default parameters (RAM_LAT = 2).
// Latency counts clock edges from the accepting edge to the edge that samples resp_valid high.
module tb_cache_assoc_wb;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_hit;
    logic [15:0] wb_count;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    cache_assoc_wb dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .wb_count   (wb_count)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic apply_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Issues one request and returns at the negedge where resp_valid is seen; lat = 99 on timeout.
    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic hit, output int lat);
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 99;
        rd  = 8'h00;
        hit = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                lat = n;
                rd  = resp_rdata;
                hit = resp_hit;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clock);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else pass_cnt++;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", resp_rdata); else pass_cnt++;
        total_cnt++; if (resp_hit !== 1'b0) $display("FAIL reset_hit got %b want 0", resp_hit); else pass_cnt++;
        total_cnt++; if (wb_count !== 16'd0) $display("FAIL reset_wb_count got %0d want 0", wb_count); else pass_cnt++;
    endtask

    task automatic test_read_miss_hit();
        logic [7:0] rd; logic hit; int lat;
        apply_reset();
        do_req(1'b0, 8'h10, 8'h00, rd, hit, lat);
        total_cnt++; if (lat !== 4) $display("FAIL miss_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rd !== 8'h10) $display("FAIL miss_rdata got %h want 10", rd); else pass_cnt++;
        total_cnt++; if (hit !== 1'b0) $display("FAIL miss_hit got %b want 0", hit); else pass_cnt++;
        @(negedge clock);
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL resp_pulse_width got %b want 0", resp_valid); else pass_cnt++;
        do_req(1'b0, 8'h10, 8'h00, rd, hit, lat);
        total_cnt++; if (lat !== 2) $display("FAIL hit_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rd !== 8'h10) $display("FAIL hit_rdata got %h want 10", rd); else pass_cnt++;
        total_cnt++; if (hit !== 1'b1) $display("FAIL hit_flag got %b want 1", hit); else pass_cnt++;
    endtask

    task automatic test_write_allocate();
        logic [7:0] rd; logic hit; int lat;
        apply_reset();
        do_req(1'b1, 8'h20, 8'hAB, rd, hit, lat);
        total_cnt++; if (lat !== 4) $display("FAIL wr_miss_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (rd !== 8'hAB) $display("FAIL wr_echo got %h want ab", rd); else pass_cnt++;
        total_cnt++; if (hit !== 1'b0) $display("FAIL wr_miss_hit got %b want 0", hit); else pass_cnt++;
        do_req(1'b0, 8'h20, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b1) $display("FAIL wr_then_rd_hit got %b want 1", hit); else pass_cnt++;
        total_cnt++; if (rd !== 8'hAB) $display("FAIL wr_then_rd_data got %h want ab", rd); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL wr_then_rd_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (dut.g_ram[32].word_q !== 8'h20) $display("FAIL wr_ram_untouched got %h want 20", dut.g_ram[32].word_q); else pass_cnt++;
    endtask

    task automatic test_lru();
        logic [7:0] rd; logic hit; int lat;
        apply_reset();
        for (int a = 1; a <= 4; a++) do_req(1'b0, 8'(a), 8'h00, rd, hit, lat);
        do_req(1'b0, 8'h01, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b1) $display("FAIL lru_touch_hit got %b want 1", hit); else pass_cnt++;
        do_req(1'b0, 8'h05, 8'h00, rd, hit, lat);
        total_cnt++; if (lat !== 4) $display("FAIL lru_clean_miss_latency got %0d want 4", lat); else pass_cnt++;
        do_req(1'b0, 8'h01, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b1) $display("FAIL lru_kept_01 got %b want 1", hit); else pass_cnt++;
        do_req(1'b0, 8'h02, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b0) $display("FAIL lru_evicted_02 got %b want 0", hit); else pass_cnt++;
    endtask

    task automatic test_dirty_evict();
        logic [7:0] rd; logic hit; int lat;
        apply_reset();
        for (int a = 1; a <= 4; a++) do_req(1'b1, 8'(a), 8'hA0 + 8'(a), rd, hit, lat);
        do_req(1'b0, 8'h05, 8'h00, rd, hit, lat);
        total_cnt++; if (lat !== 6) $display("FAIL dirty_latency got %0d want 6", lat); else pass_cnt++;
        total_cnt++; if (rd !== 8'h05) $display("FAIL dirty_rdata got %h want 05", rd); else pass_cnt++;
        total_cnt++; if (hit !== 1'b0) $display("FAIL dirty_hit got %b want 0", hit); else pass_cnt++;
        total_cnt++; if (dut.g_ram[1].word_q !== 8'hA1) $display("FAIL dirty_ram01 got %h want a1", dut.g_ram[1].word_q); else pass_cnt++;
        total_cnt++; if (wb_count !== 16'd1) $display("FAIL dirty_wb_count got %0d want 1", wb_count); else pass_cnt++;
        do_req(1'b0, 8'h02, 8'h00, rd, hit, lat);
        total_cnt++; if (rd !== 8'hA2 || hit !== 1'b1) $display("FAIL dirty_resident_02 got %h/%b want a2/1", rd, hit); else pass_cnt++;
    endtask

    task automatic test_reset_mid_writeback();
        logic [7:0] rd; logic hit; int lat; logic saw;
        apply_reset();
        for (int a = 1; a <= 4; a++) do_req(1'b1, 8'h40 + 8'(a), 8'hC0 + 8'(a), rd, hit, lat);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h45;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (resp_valid === 1'b1) saw = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid === 1'b1) saw = 1'b1;
        end
        total_cnt++; if (saw !== 1'b0) $display("FAIL midwb_no_resp got %b want 0", saw); else pass_cnt++;
        total_cnt++; if (dut.g_ram[65].word_q !== 8'h41) $display("FAIL midwb_ram41 got %h want 41", dut.g_ram[65].word_q); else pass_cnt++;
        total_cnt++; if (wb_count !== 16'd0) $display("FAIL midwb_wb_count got %0d want 0", wb_count); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL midwb_ready got %b want 1", req_ready); else pass_cnt++;
        do_req(1'b0, 8'h41, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b0) $display("FAIL midwb_next_miss got %b want 0", hit); else pass_cnt++;
        total_cnt++; if (rd !== 8'h41) $display("FAIL midwb_next_rdata got %h want 41", rd); else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        logic [7:0] rd; logic hit; int lat; int pulses; logic seen;
        apply_reset();
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        @(posedge clock);
        #1;
        req_write = 1'b1; req_addr = 8'h31; req_wdata = 8'h5A;
        @(negedge clock);
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL busy_ready got %b want 0", req_ready); else pass_cnt++;
        pulses = 0;
        seen   = 1'b0;
        rd     = 8'h00;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                pulses++;
                rd = resp_rdata;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        repeat (10) begin
            @(negedge clock);
            if (resp_valid === 1'b1) pulses++;
        end
        total_cnt++; if (pulses !== 1) $display("FAIL busy_pulses got %0d want 1", pulses); else pass_cnt++;
        total_cnt++; if (rd !== 8'h30) $display("FAIL busy_first_rdata got %h want 30", rd); else pass_cnt++;
        do_req(1'b0, 8'h31, 8'h00, rd, hit, lat);
        total_cnt++; if (hit !== 1'b0 || rd !== 8'h31) $display("FAIL busy_not_queued got %h/%b want 31/0", rd, hit); else pass_cnt++;
`ifdef CACHE_STATS_EN
        total_cnt++; if ((hit_count + miss_count) !== 16'd2) $display("FAIL stats_sum got %0d want 2", hit_count + miss_count); else pass_cnt++;
        total_cnt++; if (miss_count !== 16'd2) $display("FAIL stats_miss got %0d want 2", miss_count); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_allocate();
        test_lru();
        test_dirty_evict();
        test_reset_mid_writeback();
        test_ignore_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
